// File: rtl/led_bar_sequencer.sv
// LED bar-graph sequencer: tick divider, four animation modes, run/pause and
// single-step advance. Everything runs in the clk domain; the divider only
// produces a step enable.

// One LED: works out its offset from the origin and decides whether it is lit.
module led_bar_lane #(
  parameter int WIDTH = 18,
  parameter int PW    = 5,
  parameter int IDX   = 0
) (
  input  logic [PW-1:0] pos,
  input  logic          fill,
  input  logic          dir,
  output logic          lit
);
  localparam logic [PW-1:0] OFF_LSB = PW'(IDX);
  localparam logic [PW-1:0] OFF_MSB = PW'(WIDTH - 1 - IDX);

  logic [PW-1:0] off;

  // Lit when inside the filled span (fill modes) or at the dot position.
  always_comb begin
    off = dir ? OFF_LSB : OFF_MSB;
    lit = fill ? (off < pos) : (off == pos);
  end
endmodule

module led_bar_sequencer #(
  parameter int WIDTH = 18,
  parameter int DIV   = 25000000,
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             wrap
);
  localparam int PW = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PW-1:0]    POS_ONE  = PW'(1);
  localparam logic [PW-1:0]    POS_FULL = PW'(WIDTH);
  localparam logic [PW-1:0]    POS_LAST = PW'(WIDTH - 1);

  localparam logic [1:0] M_FILL_WRAP  = 2'b00;
  localparam logic [1:0] M_FILL_DRAIN = 2'b01;
  localparam logic [1:0] M_DOT_SCAN   = 2'b10;
  localparam logic [1:0] M_DOT_BOUNCE = 2'b11;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} phase_t;

  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PW-1:0]    pos, pos_nx;
  phase_t           phase, phase_nx;
  logic [1:0]       mode_q;
  logic             mode_chg, auto_ev, step_ev;
  logic             tick_nx, wrap_nx;
  logic [WIDTH-1:0] leds_nx;

  // Divider, step arbitration and per-mode position sequencing.
  always_comb begin
    mode_chg = (mode != mode_q);
    auto_ev  = run && (cnt == CNT_LAST);
    step_ev  = auto_ev || (!run && step);

    cnt_nx   = cnt;
    pos_nx   = pos;
    phase_nx = phase;
    tick_nx  = 1'b0;
    wrap_nx  = 1'b0;

    if (run) cnt_nx = auto_ev ? '0 : cnt + CNT_ONE;

    if (mode_chg) begin
      // New mode restarts the sequence; a coincident step is dropped.
      cnt_nx   = '0;
      pos_nx   = '0;
      phase_nx = UP;
    end else if (step_ev) begin
      tick_nx = 1'b1;
      case (mode_q)
        M_FILL_WRAP: begin
          if (pos == POS_FULL) begin
            pos_nx  = '0;
            wrap_nx = 1'b1;
          end else pos_nx = pos + POS_ONE;
        end
        M_FILL_DRAIN: begin
          if (phase == UP) begin
            pos_nx = pos + POS_ONE;
            if (pos_nx == POS_FULL) phase_nx = DOWN;
          end else begin
            pos_nx = pos - POS_ONE;
            if (pos_nx == '0) begin
              phase_nx = UP;
              wrap_nx  = 1'b1;
            end
          end
        end
        M_DOT_SCAN: begin
          if (pos == POS_LAST) begin
            pos_nx  = '0;
            wrap_nx = 1'b1;
          end else pos_nx = pos + POS_ONE;
        end
        M_DOT_BOUNCE: begin
          if (phase == UP) begin
            pos_nx = pos + POS_ONE;
            if (pos_nx == POS_LAST) phase_nx = DOWN;
          end else begin
            pos_nx = pos - POS_ONE;
            if (pos_nx == '0) begin
              phase_nx = UP;
              wrap_nx  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Display is built from next-state pos and the incoming mode, so leds
  // change on the same edge as the step that moved them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    led_bar_lane #(.WIDTH(WIDTH), .PW(PW), .IDX(i)) u_lane (
      .pos  (pos_nx),
      .fill (~mode[1]),
      .dir  (dir),
      .lit  (leds_nx[i])
    );
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      pos    <= '0;
      phase  <= UP;
      mode_q <= mode;
      leds   <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      pos    <= pos_nx;
      phase  <= phase_nx;
      mode_q <= mode;
      leds   <= leds_nx;
      tick   <= tick_nx;
      wrap   <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_led_bar_sequencer.sv
// Bench for led_bar_sequencer with WIDTH=4, DIV=3.
module tb_led_bar_sequencer;
  localparam int W = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset, run, step, dir;
  logic [1:0]   mode;
  logic [W-1:0] leds;
  logic         tick, wrap;

  led_bar_sequencer #(.WIDTH(W), .DIV(D), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .step  (step),
    .mode  (mode),
    .dir   (dir),
    .leds  (leds),
    .tick  (tick),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] leds;
    logic         wrap;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string           name;
    logic [1:0]      mode;
    logic            dir;
    int              n;
    logic [8:0][W-1:0] seq;  // seq[k] = pattern after k steps
    logic [8:0]      wr;     // bit k = wrap expected on step k
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] l, input logic w);
    exp_t e;
    e.leds = l;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Wait for n ticks; compare each against the scoreboard and check spacing.
  task automatic expect_steps(input int n, input int first_lat, input string name);
    int   cyc  = 0;
    int   last = -1;
    int   got  = 0;
    exp_t e;
    while (got < n && cyc < first_lat + n * D + 10) begin
      @(negedge clk);
      cyc++;
      if (tick) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s unexpected tick at cycle %0d", name, cyc);
        end else begin
          e = sb.pop_front();
          chk({name, " leds"}, 32'(leds), 32'(e.leds));
          chk({name, " wrap"}, 32'(wrap), 32'(e.wrap));
        end
        if (last < 0) begin
          if (first_lat > 0) chk({name, " first latency"}, cyc, first_lat);
        end else chk({name, " step spacing"}, cyc - last, D);
        last = cyc;
        got++;
      end else begin
        chk({name, " wrap without tick"}, 32'(wrap), 0);
      end
    end
    if (got < n) chk({name, " tick count (timeout)"}, got, n);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic d);
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    mode  = m;
    dir   = d;
    repeat (2) @(negedge clk);
    chk("reset leds", 32'(leds), 0);
    chk("reset tick", 32'(tick), 0);
    chk("reset wrap", 32'(wrap), 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; mode = 2'b00; dir = 1'b0;

    tbl[0] = '{"fill-wrap", 2'b00, 1'b0, 5,
      {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000},
      9'h020};
    tbl[1] = '{"fill-drain", 2'b01, 1'b1, 8,
      {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000},
      9'h100};
    tbl[2] = '{"dot-scan", 2'b10, 1'b1, 4,
      {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001},
      9'h010};
    tbl[3] = '{"dot-bounce", 2'b11, 1'b0, 6,
      {4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000},
      9'h040};

    // Full period of each mode, plus one more step to show it carries on.
    for (int v = 0; v < 4; v++) begin
      do_reset(tbl[v].mode, tbl[v].dir);
      chk({tbl[v].name, " start leds"}, 32'(leds), 32'(tbl[v].seq[0]));
      chk({tbl[v].name, " start tick"}, 32'(tick), 0);
      run = 1'b1;
      for (int k = 1; k <= tbl[v].n; k++) push(tbl[v].seq[k], tbl[v].wr[k]);
      push(tbl[v].seq[1], 1'b0);
      expect_steps(tbl[v].n + 1, D, tbl[v].name);
    end

    // Pause and manual step.
    do_reset(2'b00, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("pause leds", 32'(leds), 0);
      chk("pause tick", 32'(tick), 0);
    end
    step = 1'b1;
    push(4'b1000, 1'b0);
    expect_steps(1, 1, "step1");
    step = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("step1 tick low", 32'(tick), 0);
      chk("step1 hold", 32'(leds), 32'(4'b1000));
    end
    step = 1'b1;
    push(4'b1100, 1'b0);
    expect_steps(1, 1, "step2");
    step = 1'b0;
    run  = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step while run leds", 32'(leds), 32'(4'b1100));
    chk("step while run tick", 32'(tick), 0);
    push(4'b1110, 1'b0);
    expect_steps(1, 2, "resume");
    run = 1'b0;

    // Mode change mid-sequence at pos=3.
    do_reset(2'b01, 1'b0);
    run = 1'b1;
    push(4'b1000, 1'b0); push(4'b1100, 1'b0); push(4'b1110, 1'b0);
    expect_steps(3, D, "pre-change");
    mode = 2'b10;
    @(negedge clk);
    chk("mode change leds", 32'(leds), 32'(4'b1000));
    chk("mode change tick", 32'(tick), 0);
    chk("mode change wrap", 32'(wrap), 0);
    push(4'b0100, 1'b0); push(4'b0010, 1'b0);
    expect_steps(2, D, "post-change");

    // Direction flip only remaps the display.
    do_reset(2'b00, 1'b0);
    run = 1'b1;
    push(4'b1000, 1'b0); push(4'b1100, 1'b0);
    expect_steps(2, D, "pre-flip");
    dir = 1'b1;
    @(negedge clk);
    chk("dir flip leds", 32'(leds), 32'(4'b0011));
    chk("dir flip tick", 32'(tick), 0);
    push(4'b0111, 1'b0);
    expect_steps(1, 2, "post-flip");

    // Reset coincident with an auto step.
    do_reset(2'b00, 1'b0);
    run = 1'b1;
    push(4'b1000, 1'b0);
    expect_steps(1, D, "pre-reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset leds", 32'(leds), 0);
    chk("mid reset tick", 32'(tick), 0);
    chk("mid reset wrap", 32'(wrap), 0);
    reset = 1'b0;
    push(4'b1000, 1'b0);
    expect_steps(1, D, "post-reset");

    chk("scoreboard empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
